// File: rtl/tuner_phy_ctrl_arb_multi.sv
// Round-robin arbiter sharing one tuner DAC and one power detector among NUM_CH
// search/lock controllers; each grant runs INIT -> TUNE -> SYNC -> COMMIT.
module tuner_phy_ctrl_arb_multi #(
    parameter int NUM_CH         = 2,
    parameter int CODE_WIDTH     = 8,
    parameter int PWR_WIDTH      = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH*CODE_WIDTH-1:0] ch_code,
    input  logic [NUM_CH-1:0]            ch_commit,
    output logic [NUM_CH-1:0]            ch_gnt,
    output logic [NUM_CH-1:0]            ch_pwr_valid,
    output logic [PWR_WIDTH-1:0]         ch_pwr,
    output logic [CODE_WIDTH-1:0]        tuner_code,
    output logic                         tuner_code_valid,
    input  logic [PWR_WIDTH-1:0]         pwr_in,
    input  logic                         pwr_valid_in,
    output logic [1:0]                   arb_state,
    output logic                         err_timeout
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_CNT  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_CH     = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_TUNE   = 2'd1,
        S_SYNC   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win_idx;
    logic [CNT_W-1:0]   sync_cnt;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [CODE_WIDTH-1:0] pick_code;
    int                 pick_pos;

    logic               win_req;
    logic               win_commit;
    logic [IDX_W-1:0]   next_ptr;
    logic [CNT_W-1:0]   cnt_inc;
    logic               sample_ok;

    function automatic logic [NUM_CH-1:0] one_hot(input logic [IDX_W-1:0] idx);
        one_hot = NUM_CH'(1) << idx;
    endfunction

    // Scan from the highest offset down so the nearest requester at or after
    // rr_ptr is the one left standing.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_pos   = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            pick_pos = (int'(rr_ptr) + k) % NUM_CH;
            if (ch_req[IDX_W'(pick_pos)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(pick_pos);
            end
        end
    end

    always_comb begin
        pick_code = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_code = ch_code[i*CODE_WIDTH +: CODE_WIDTH];
            end
        end
    end

    assign win_req    = ch_req[win_idx];
    assign win_commit = ch_commit[win_idx];
    assign next_ptr   = (win_idx == LAST_CH) ? '0 : win_idx + IDX_W'(1);
    assign cnt_inc    = (sync_cnt == TIMEOUT_CNT) ? sync_cnt : sync_cnt + CNT_W'(1);
    assign sample_ok  = pwr_valid_in && (sync_cnt >= SETTLE_CNT);
    assign arb_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_INIT;
            rr_ptr           <= '0;
            win_idx          <= '0;
            sync_cnt         <= '0;
            ch_gnt           <= '0;
            ch_pwr_valid     <= '0;
            ch_pwr           <= '0;
            tuner_code       <= '0;
            tuner_code_valid <= 1'b0;
            err_timeout      <= 1'b0;
        end else begin
            tuner_code_valid <= 1'b0;
            ch_pwr_valid     <= '0;
            err_timeout      <= 1'b0;

            case (state)
                S_INIT: begin
                    if (pick_found) begin
                        win_idx          <= pick_idx;
                        tuner_code       <= pick_code;
                        tuner_code_valid <= 1'b1;
                        ch_gnt           <= one_hot(pick_idx);
                        state            <= S_TUNE;
                    end
                end

                S_TUNE: begin
                    if (!win_req) begin
                        ch_gnt <= '0;
                        rr_ptr <= next_ptr;
                        state  <= S_INIT;
                    end else begin
                        sync_cnt <= '0;
                        state    <= S_SYNC;
                    end
                end

                S_SYNC: begin
                    sync_cnt <= cnt_inc;
                    if (!win_req) begin
                        ch_gnt <= '0;
                        rr_ptr <= next_ptr;
                        state  <= S_INIT;
                    end else if (sample_ok) begin
                        // A sample on the timeout cycle still wins.
                        ch_pwr       <= pwr_in;
                        ch_pwr_valid <= ch_gnt;
                        state        <= S_COMMIT;
                    end else if (cnt_inc == TIMEOUT_CNT) begin
                        err_timeout <= 1'b1;
                        ch_gnt      <= '0;
                        rr_ptr      <= next_ptr;
                        state       <= S_INIT;
                    end
                end

                S_COMMIT: begin
                    if (!win_req || win_commit) begin
                        ch_gnt <= '0;
                        rr_ptr <= next_ptr;
                        state  <= S_INIT;
                    end
                end

                default: begin
                    ch_gnt <= '0;
                    state  <= S_INIT;
                end
            endcase
        end
    end

endmodule
